// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Module : accel_pkg
// Brief  : Shared constants and types for the matrix accelerator datapath.
// Rev    : 1.0  initial release
// ============================================================================
package accel_pkg;

    localparam int WORD_W = 32;
    localparam int LINE_W = 256;
    localparam int WORDS  = LINE_W / WORD_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PUSH = 3'd3,
        ST_DONE = 3'd4
    } dma_rd_state_t;

endpackage
`default_nettype wire

// File: rtl/line_packer.sv
`default_nettype none
// ============================================================================
// Module : line_packer
// Brief  : Collects bus words into one line register, word 0 in the LSBs.
// Rev    : 1.0  initial release
// ============================================================================
module line_packer #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] slot,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] line
);

    localparam int WORDS = LINE_W / WORD_W;

    logic [WORDS-1:0] slot_we;

    generate
        for (genvar i = 0; i < WORDS; i++) begin : g_dec
            assign slot_we[i] = wr_en && (slot == SLOT_W'(i));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line <= '0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (slot_we[i]) begin
                    line[i*WORD_W +: WORD_W] <= wdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_read_engine.sv
`default_nettype none
// ============================================================================
// Module : dma_read_engine
// Brief  : Single-outstanding word reader that packs words into lines.
// Rev    : 1.0  initial release
// ============================================================================
module dma_read_engine #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = accel_pkg::WORD_W,
    parameter int LINE_W = accel_pkg::LINE_W,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    output logic              dma_busy,
    output logic              dma_done,
    output logic [LINE_W-1:0] dma_data,
    output logic              dma_valid,
    input  logic              dma_ready,
    output logic              m_rd_req,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic              m_rd_ack,
    input  logic              m_rd_rvalid,
    input  logic [WORD_W-1:0] m_rd_rdata
);

    import accel_pkg::*;

    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int CNT_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    dma_rd_state_t     state;
    dma_rd_state_t     state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  line_cnt;
    logic              busy_q;

    logic start_ok;
    logic word_fire;
    logic last_word;
    logic line_fire;
    logic last_line;
    logic unused_addr_bits;

    // Byte offset within the first word is discarded at latch time.
    assign unused_addr_bits = ^dma_addr[1:0];

    assign start_ok  = (state == ST_IDLE) && dma_start;
    // Data arriving together with the ack is taken as if already in WAIT.
    assign word_fire = m_rd_rvalid &&
                       ((state == ST_WAIT) || ((state == ST_REQ) && m_rd_ack));
    assign last_word = (word_cnt == CNT_W'(WORDS_PER_LINE - 1));
    assign line_fire = (state == ST_PUSH) && dma_ready;
    assign last_line = ((line_cnt + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        m_rd_req  = 1'b0;
        dma_valid = 1'b0;
        dma_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dma_start) begin
                    state_nx = (dma_len == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                m_rd_req = 1'b1;
                if (word_fire) begin
                    state_nx = last_word ? ST_PUSH : ST_REQ;
                end else if (m_rd_ack) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (word_fire) begin
                    state_nx = last_word ? ST_PUSH : ST_REQ;
                end
            end
            ST_PUSH: begin
                dma_valid = 1'b1;
                if (dma_ready) begin
                    state_nx = last_line ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                dma_done = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            len_q    <= '0;
            word_cnt <= '0;
            line_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (state == ST_DONE) begin
                busy_q <= 1'b0;
            end

            if (start_ok && (dma_len != '0)) begin
                addr_q   <= {dma_addr[ADDR_W-1:2], 2'b00};
                len_q    <= dma_len;
                word_cnt <= '0;
                line_cnt <= '0;
            end

            if (word_fire) begin
                addr_q <= addr_q + ADDR_W'(4);
                if (!last_word) begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end

            if (line_fire) begin
                line_cnt <= line_cnt + LEN_W'(1);
                word_cnt <= '0;
            end
        end
    end

    assign m_rd_addr = addr_q;
    assign dma_busy  = busy_q;

    line_packer #(
        .WORD_W (WORD_W),
        .LINE_W (LINE_W),
        .SLOT_W (CNT_W)
    ) u_packer (
        .clk   (clk),
        .rstn  (rstn),
        .wr_en (word_fire),
        .slot  (word_cnt),
        .wdata (m_rd_rdata),
        .line  (dma_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_dma_read_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_dma_read_engine
// Brief  : Scoreboard bench with a randomized-latency memory slave.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dma_read_engine;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         dma_start = 1'b0;
    logic [31:0]  dma_addr = '0;
    logic [15:0]  dma_len = '0;
    logic         dma_busy, dma_done, dma_valid;
    logic [255:0] dma_data;
    logic         dma_ready = 1'b0;
    logic         m_rd_req;
    logic [31:0]  m_rd_addr;
    logic         m_rd_ack, m_rd_rvalid;
    logic [31:0]  m_rd_rdata;

    logic         sl_ack = 1'b0, sl_rvalid = 1'b0;
    logic [31:0]  sl_rdata = '0;
    logic         man_ack = 1'b0, man_rvalid = 1'b0;
    logic [31:0]  man_rdata = '0;
    bit           manual_bus = 1'b0;

    assign m_rd_ack    = manual_bus ? man_ack    : sl_ack;
    assign m_rd_rvalid = manual_bus ? man_rvalid : sl_rvalid;
    assign m_rd_rdata  = manual_bus ? man_rdata  : sl_rdata;

    always #5 clk = ~clk;

    dma_read_engine dut (
        .clk         (clk),
        .rstn        (rstn),
        .dma_start   (dma_start),
        .dma_addr    (dma_addr),
        .dma_len     (dma_len),
        .dma_busy    (dma_busy),
        .dma_done    (dma_done),
        .dma_data    (dma_data),
        .dma_valid   (dma_valid),
        .dma_ready   (dma_ready),
        .m_rd_req    (m_rd_req),
        .m_rd_addr   (m_rd_addr),
        .m_rd_ack    (m_rd_ack),
        .m_rd_rvalid (m_rd_rvalid),
        .m_rd_rdata  (m_rd_rdata)
    );

    int           vectors = 0;
    int           miscompares = 0;
    logic [31:0]  exp_addr_q[$];
    logic [255:0] exp_line_q[$];
    logic [31:0]  mem_key = '0;
    bit           force_ready = 1'b0;
    int           stall_line = -1;
    int           stall_left = 0;
    int           lines_acc = 0;
    int           done_cnt = 0;
    int           ack_cnt = 0;
    bit           req_seen = 1'b0;
    int           cyc = 0;
    int           last_hs_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mem_key;
    endfunction

    // Reference: words come from consecutive aligned addresses, 8 per line, LSW first.
    task automatic push_expect(input logic [31:0] addr, input int len);
        logic [31:0]  a;
        logic [255:0] line;
        a = {addr[31:2], 2'b00};
        for (int j = 0; j < len; j++) begin
            line = '0;
            for (int i = 0; i < 8; i++) begin
                exp_addr_q.push_back(a);
                line[32*i +: 32] = mem_word(a);
                a = a + 32'd4;
            end
            exp_line_q.push_back(line);
        end
    endtask

    initial begin : bus_slave
        logic [31:0] a;
        int ad;
        int rd;
        forever begin
            @(negedge clk);
            sl_rdata = $urandom;
            if (!manual_bus && rstn && m_rd_req) begin
                a  = m_rd_addr;
                ad = $urandom_range(0, 3);
                rd = $urandom_range(0, 4);
                for (int i = 0; i < ad; i++) begin
                    @(negedge clk);
                    check("req_held", m_rd_req, 1);
                    check("addr_held", m_rd_addr, a);
                end
                sl_ack = 1'b1;
                ack_cnt++;
                if (exp_addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL req_unexpected: got request at %h, none expected", a);
                end else begin
                    check("req_addr", a, exp_addr_q.pop_front());
                end
                if (rd == 0) begin
                    sl_rvalid = 1'b1;
                    sl_rdata  = mem_word(a);
                end
                @(negedge clk);
                sl_ack    = 1'b0;
                sl_rvalid = 1'b0;
                sl_rdata  = $urandom;
                if (rd > 0) begin
                    repeat (rd - 1) @(negedge clk);
                    sl_rvalid = 1'b1;
                    sl_rdata  = mem_word(a);
                    @(negedge clk);
                    sl_rvalid = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(negedge clk);
            if (stall_left > 0 && dma_valid && lines_acc == stall_line) begin
                dma_ready = 1'b0;
                stall_left--;
            end else if (force_ready) begin
                dma_ready = 1'b1;
            end else begin
                dma_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : monitor
        logic [255:0] held;
        bit hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                hold = 1'b0;
            end else begin
                if (m_rd_req) req_seen = 1'b1;
                if (dma_done) done_cnt++;
                if (hold) begin
                    check("stall_valid", dma_valid, 1);
                    check("stall_data", dma_data, held);
                end
                if (dma_valid) check("no_req_while_valid", m_rd_req, 0);
                hold = 1'b0;
                if (dma_valid) begin
                    if (dma_ready) begin
                        if (exp_line_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL line_unexpected: got %h", dma_data);
                        end else begin
                            check("line_data", dma_data, exp_line_q.pop_front());
                        end
                        lines_acc++;
                        last_hs_edge = cyc + 1;
                    end else begin
                        hold = 1'b1;
                        held = dma_data;
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] addr, input int len);
        @(negedge clk);
        dma_start = 1'b1;
        dma_addr  = addr;
        dma_len   = 16'(len);
        @(negedge clk);
        dma_start = 1'b0;
        dma_addr  = $urandom;
        dma_len   = 16'($urandom);
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int len, input logic [31:0] key,
                            input int stall_ln, input bit inject);
        int d0;
        int a0;
        bit got;
        mem_key    = key;
        push_expect(addr, len);
        stall_line = stall_ln;
        stall_left = (stall_ln >= 0) ? 5 : 0;
        lines_acc  = 0;
        d0         = done_cnt;
        a0         = ack_cnt;
        req_seen   = 1'b0;
        do_start(addr, len);
        check("busy_after_start", dma_busy, 1);
        if (len == 0) begin
            check("done_len0", dma_done, 1);
        end else begin
            check("first_req", m_rd_req, 1);
            check("first_addr", m_rd_addr, {addr[31:2], 2'b00});
        end
        if (inject) begin
            repeat (3) @(negedge clk);
            dma_start = 1'b1;
            dma_addr  = 32'h5555_0000;
            dma_len   = 16'd7;
            @(negedge clk);
            dma_start = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 5000 && !got; c++) begin
            if (dma_done) got = 1'b1;
            else @(negedge clk);
        end
        check("done_seen", got, 1);
        if (got) begin
            check("busy_at_done", dma_busy, 1);
            if (len > 0) check("done_after_hs", cyc, last_hs_edge);
            @(negedge clk);
            check("busy_drop", dma_busy, 0);
            check("done_one_cycle", dma_done, 0);
        end
        repeat (4) @(negedge clk);
        check("done_count", done_cnt - d0, 1);
        check("req_count", ack_cnt - a0, 8 * len);
        check("lines_left", exp_line_q.size(), 0);
        check("addrs_left", exp_addr_q.size(), 0);
        if (len == 0) check("no_req_len0", req_seen, 0);
        exp_line_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic reset_abort_test();
        logic [31:0] base;
        bit ok;
        base        = 32'h2000_0104;
        manual_bus  = 1'b1;
        force_ready = 1'b1;
        do_start(base, 2);
        for (int w = 0; w < 4; w++) begin
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                if (m_rd_req) ok = 1'b1;
                else @(negedge clk);
            end
            check("rst_req_seen", ok, 1);
            check("rst_req_addr", m_rd_addr, base + 32'(4 * w));
            man_ack = 1'b1;
            if (w < 3) begin
                man_rvalid = 1'b1;
                man_rdata  = base + 32'(4 * w);
                @(negedge clk);
                man_ack    = 1'b0;
                man_rvalid = 1'b0;
            end else begin
                @(negedge clk);
                man_ack    = 1'b0;
                man_rvalid = 1'b1;
                man_rdata  = 32'hDEAD_BEEF;
                #1 rstn = 1'b0;
                #1;
                check("arst_busy", dma_busy, 0);
                check("arst_done", dma_done, 0);
                check("arst_valid", dma_valid, 0);
                check("arst_data", dma_data, 0);
                check("arst_req", m_rd_req, 0);
                check("arst_addr", m_rd_addr, 0);
                @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);
                man_rvalid = 1'b0;
                check("post_rst_busy", dma_busy, 0);
                check("post_rst_req", m_rd_req, 0);
                check("post_rst_valid", dma_valid, 0);
                check("post_rst_data", dma_data, 0);
            end
        end
        manual_bus  = 1'b0;
        force_ready = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (3) @(negedge clk);
        check("rst_busy", dma_busy, 0);
        check("rst_done", dma_done, 0);
        check("rst_valid", dma_valid, 0);
        check("rst_data", dma_data, 0);
        check("rst_req", m_rd_req, 0);
        check("rst_addr", m_rd_addr, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(32'h1000_0010, 1, 32'h0, -1, 1'b0);
        run_xfer(32'h0000_4000, 3, 32'hA5A5_5A5A, 1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            run_xfer($urandom, $urandom_range(1, 3), $urandom, -1, 1'b0);
        end
        run_xfer(32'h0000_8000, 0, 32'h0, -1, 1'b0);
        run_xfer(32'h0000_9008, 2, 32'h1234_5678, -1, 1'b1);
        run_xfer(32'hFFFF_FFF3, 1, 32'h0, -1, 1'b0);
        reset_abort_test();
        run_xfer(32'h3000_0200, 1, 32'h0F0F_F0F0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
